// File: rtl/hamming_secded_fifo.sv
// hamming_secded_fifo: FIFO storing extended-Hamming (SECDED) codewords, with write-side
// error injection, registered single-error correction / double-error detection and saturating event counters.
module hamming_secded_fifo #(
    parameter int DW = 32,
    parameter int DEPTH = 4,
    parameter int CNTW = 16,
    localparam int PW = $clog2(DW + 1 + $clog2(DW + 1 + $clog2(DW + 1))),
    localparam int CW = DW + PW + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_wreq,
    input  logic [DW-1:0]   i_wdata,
    input  logic [CW-1:0]   i_inj_mask,
    input  logic            i_rreq,
    output logic            o_rvalid,
    output logic [DW-1:0]   o_rdata,
    output logic            o_sec,
    output logic            o_ded,
    output logic [PW-1:0]   o_err_pos,
    output logic            o_empty,
    output logic            o_full,
    output logic [AW:0]     o_count,
    output logic            o_wr_ovf,
    output logic            o_rd_udf,
    input  logic            i_cnt_clr,
    output logic [CNTW-1:0] o_sec_cnt,
    output logic [CNTW-1:0] o_ded_cnt
);
    localparam logic [PW-1:0] NPOS = PW'(DW + PW);

    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                j++;
            end
        // Parity slots are still zero here, so each parity bit can fold in its own slot harmlessly.
        for (int k = 0; k < PW; k++)
            for (int pos = 1; pos < CW; pos++)
                if (((pos >> k) & 1) != 0) c[1 << k] = c[1 << k] ^ c[pos];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [DW-1:0] extract(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < CW; pos++)
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos];
                j++;
            end
        return d;
    endfunction

    logic [CW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt_next;
    logic          wr_acc, rd_acc;
    logic [CW-1:0] head, fixed;
    logic [PW-1:0] syn;
    logic          q, dec_sec, dec_ded;

    assign wr_acc = i_wreq && (!o_full || i_rreq);
    assign rd_acc = i_rreq && !o_empty;
    assign cnt_next = o_count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    assign head = mem[rd_ptr];

    always_comb begin
        syn = '0;
        for (int i = 1; i < CW; i++)
            syn = head[i] ? syn ^ PW'(i) : syn;
        q = ^head;
        fixed = head;
        for (int i = 1; i < CW; i++)
            fixed[i] = head[i] ^ (q && syn == PW'(i));
        dec_sec = q && syn <= NPOS;
        dec_ded = q ? syn > NPOS : syn != '0;
    end

    always_ff @(posedge clk)
        if (wr_acc) mem[wr_ptr] <= encode(i_wdata) ^ i_inj_mask;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_count   <= '0;
            o_empty   <= 1'b1;
            o_full    <= 1'b0;
            o_wr_ovf  <= 1'b0;
            o_rd_udf  <= 1'b0;
            o_rvalid  <= 1'b0;
            o_rdata   <= '0;
            o_sec     <= 1'b0;
            o_ded     <= 1'b0;
            o_err_pos <= '0;
            o_sec_cnt <= '0;
            o_ded_cnt <= '0;
        end else begin
            wr_ptr   <= wr_ptr + AW'(wr_acc);
            rd_ptr   <= rd_ptr + AW'(rd_acc);
            o_count  <= cnt_next;
            o_empty  <= cnt_next == '0;
            o_full   <= cnt_next == (AW+1)'(DEPTH);
            o_wr_ovf <= i_wreq && !wr_acc;
            o_rd_udf <= i_rreq && o_empty;
            o_rvalid <= rd_acc;
            if (rd_acc) begin
                o_rdata   <= extract(fixed);
                o_sec     <= dec_sec;
                o_ded     <= dec_ded;
                o_err_pos <= dec_sec ? syn : '0;
            end
            o_sec_cnt <= i_cnt_clr ? '0 : (rd_acc && dec_sec && !(&o_sec_cnt)) ? o_sec_cnt + 1'b1 : o_sec_cnt;
            o_ded_cnt <= i_cnt_clr ? '0 : (rd_acc && dec_ded && !(&o_ded_cnt)) ? o_ded_cnt + 1'b1 : o_ded_cnt;
        end
    end
endmodule

// File: tb/tb_hamming_secded_fifo.sv
// tb_hamming_secded_fifo: directed checks of the SECDED FIFO with DW=8, DEPTH=4, CNTW=4 (PW=4, CW=13).
module tb_hamming_secded_fifo;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_wreq = 1'b0;
    logic [7:0]  i_wdata = '0;
    logic [12:0] i_inj_mask = '0;
    logic        i_rreq = 1'b0;
    logic        i_cnt_clr = 1'b0;
    logic        o_rvalid, o_sec, o_ded, o_empty, o_full, o_wr_ovf, o_rd_udf;
    logic [7:0]  o_rdata;
    logic [3:0]  o_err_pos, o_sec_cnt, o_ded_cnt;
    logic [2:0]  o_count;
    int n_cmp = 0;
    int n_bad = 0;

    hamming_secded_fifo #(.DW(8), .DEPTH(4), .CNTW(4)) dut (
        .clk(clk), .reset_n(reset_n), .i_wreq(i_wreq), .i_wdata(i_wdata), .i_inj_mask(i_inj_mask),
        .i_rreq(i_rreq), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_sec(o_sec), .o_ded(o_ded),
        .o_err_pos(o_err_pos), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
        .o_wr_ovf(o_wr_ovf), .o_rd_udf(o_rd_udf), .i_cnt_clr(i_cnt_clr),
        .o_sec_cnt(o_sec_cnt), .o_ded_cnt(o_ded_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d, input logic [12:0] m);
        i_wreq = 1'b1; i_wdata = d; i_inj_mask = m;
        step();
        i_wreq = 1'b0; i_inj_mask = '0;
    endtask

    task automatic do_read();
        i_rreq = 1'b1;
        step();
        i_rreq = 1'b0;
    endtask

    task automatic test_reset();
        step();
        reset_n = 1'b1;
        step();
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d exp 0", o_count); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b exp 1", o_empty); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b exp 0", o_full); end
        n_cmp++; if ({o_rvalid, o_sec, o_ded, o_wr_ovf, o_rd_udf} !== 5'b0) begin n_bad++; $display("FAIL rst_flags: got %b exp 00000", {o_rvalid, o_sec, o_ded, o_wr_ovf, o_rd_udf}); end
        n_cmp++; if ({o_rdata, o_err_pos, o_sec_cnt, o_ded_cnt} !== 20'h0) begin n_bad++; $display("FAIL rst_data: got %h exp 0", {o_rdata, o_err_pos, o_sec_cnt, o_ded_cnt}); end
    endtask

    task automatic test_clean();
        do_write(8'hA5, 13'h0);
        n_cmp++; if (o_count !== 3'd1 || o_empty !== 1'b0) begin n_bad++; $display("FAIL clean_count: got %0d/%b exp 1/0", o_count, o_empty); end
        do_read();
        n_cmp++; if (o_rvalid !== 1'b1) begin n_bad++; $display("FAIL clean_rvalid: got %b exp 1", o_rvalid); end
        n_cmp++; if (o_rdata !== 8'hA5) begin n_bad++; $display("FAIL clean_rdata: got %h exp a5", o_rdata); end
        n_cmp++; if ({o_sec, o_ded} !== 2'b00) begin n_bad++; $display("FAIL clean_status: got %b exp 00", {o_sec, o_ded}); end
        n_cmp++; if ({o_sec_cnt, o_ded_cnt} !== 8'h00) begin n_bad++; $display("FAIL clean_cnt: got %h exp 00", {o_sec_cnt, o_ded_cnt}); end
        step();
        n_cmp++; if (o_rvalid !== 1'b0 || o_rdata !== 8'hA5) begin n_bad++; $display("FAIL clean_hold: got %b/%h exp 0/a5", o_rvalid, o_rdata); end
    endtask

    task automatic test_sec();
        do_write(8'hA5, 13'h0020);
        do_read();
        n_cmp++; if (o_rdata !== 8'hA5) begin n_bad++; $display("FAIL sec_rdata: got %h exp a5", o_rdata); end
        n_cmp++; if ({o_rvalid, o_sec, o_ded} !== 3'b110) begin n_bad++; $display("FAIL sec_status: got %b exp 110", {o_rvalid, o_sec, o_ded}); end
        n_cmp++; if (o_err_pos !== 4'd5) begin n_bad++; $display("FAIL sec_pos: got %0d exp 5", o_err_pos); end
        n_cmp++; if (o_sec_cnt !== 4'd1) begin n_bad++; $display("FAIL sec_cnt: got %0d exp 1", o_sec_cnt); end
    endtask

    task automatic test_ded();
        do_write(8'hA5, 13'h0048);
        do_read();
        n_cmp++; if ({o_sec, o_ded} !== 2'b01) begin n_bad++; $display("FAIL ded_status: got %b exp 01", {o_sec, o_ded}); end
        n_cmp++; if (o_rdata !== 8'hA0) begin n_bad++; $display("FAIL ded_rdata: got %h exp a0", o_rdata); end
        n_cmp++; if (o_err_pos !== 4'd0) begin n_bad++; $display("FAIL ded_pos: got %0d exp 0", o_err_pos); end
        n_cmp++; if (o_ded_cnt !== 4'd1 || o_sec_cnt !== 4'd1) begin n_bad++; $display("FAIL ded_cnt: got %0d/%0d exp 1/1", o_ded_cnt, o_sec_cnt); end
        do_write(8'hA5, 13'h0001);
        do_read();
        n_cmp++; if ({o_sec, o_ded} !== 2'b10 || o_err_pos !== 4'd0) begin n_bad++; $display("FAIL p0_status: got %b pos %0d exp 10 pos 0", {o_sec, o_ded}, o_err_pos); end
        n_cmp++; if (o_rdata !== 8'hA5) begin n_bad++; $display("FAIL p0_rdata: got %h exp a5", o_rdata); end
        n_cmp++; if (o_sec_cnt !== 4'd2) begin n_bad++; $display("FAIL p0_cnt: got %0d exp 2", o_sec_cnt); end
    endtask

    task automatic test_full();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) do_write(8'(i), 13'h0);
        n_cmp++; if (o_full !== 1'b1 || o_count !== 3'd4) begin n_bad++; $display("FAIL full_state: got %b/%0d exp 1/4", o_full, o_count); end
        do_write(8'h99, 13'h0);
        n_cmp++; if (o_wr_ovf !== 1'b1 || o_count !== 3'd4) begin n_bad++; $display("FAIL ovf: got %b/%0d exp 1/4", o_wr_ovf, o_count); end
        step();
        n_cmp++; if (o_wr_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse: got %b exp 0", o_wr_ovf); end
        i_rreq = 1'b1;
        do_write(8'h05, 13'h0);
        i_rreq = 1'b0;
        n_cmp++; if (o_rvalid !== 1'b1 || o_rdata !== 8'h01) begin n_bad++; $display("FAIL rw_full_rdata: got %b/%h exp 1/01", o_rvalid, o_rdata); end
        n_cmp++; if (o_count !== 3'd4 || o_full !== 1'b1 || o_wr_ovf !== 1'b0) begin n_bad++; $display("FAIL rw_full_count: got %0d/%b/%b exp 4/1/0", o_count, o_full, o_wr_ovf); end
        for (int i = 2; i <= 5; i++) begin
            exp = 8'(i);
            do_read();
            n_cmp++; if (o_rvalid !== 1'b1 || o_rdata !== exp) begin n_bad++; $display("FAIL drain_%0d: got %b/%h exp 1/%h", i, o_rvalid, o_rdata, exp); end
        end
        n_cmp++; if (o_empty !== 1'b1 || o_count !== 3'd0 || o_full !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b/%0d/%b exp 1/0/0", o_empty, o_count, o_full); end
    endtask

    task automatic test_underflow();
        do_read();
        n_cmp++; if (o_rd_udf !== 1'b1 || o_rvalid !== 1'b0) begin n_bad++; $display("FAIL udf: got %b/%b exp 1/0", o_rd_udf, o_rvalid); end
        step();
        n_cmp++; if (o_rd_udf !== 1'b0) begin n_bad++; $display("FAIL udf_pulse: got %b exp 0", o_rd_udf); end
        i_rreq = 1'b1;
        do_write(8'h3C, 13'h0);
        i_rreq = 1'b0;
        n_cmp++; if (o_count !== 3'd1 || o_rvalid !== 1'b0 || o_rd_udf !== 1'b1) begin n_bad++; $display("FAIL rw_empty: got %0d/%b/%b exp 1/0/1", o_count, o_rvalid, o_rd_udf); end
        do_read();
        n_cmp++; if (o_rvalid !== 1'b1 || o_rdata !== 8'h3C) begin n_bad++; $display("FAIL rw_empty_rdata: got %b/%h exp 1/3c", o_rvalid, o_rdata); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i), 13'h0020);
            do_read();
        end
        n_cmp++; if (o_sec_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_cnt: got %0d exp 15", o_sec_cnt); end
        n_cmp++; if (o_rdata !== 8'h0F || o_sec !== 1'b1) begin n_bad++; $display("FAIL sat_rdata: got %h/%b exp 0f/1", o_rdata, o_sec); end
        do_write(8'h77, 13'h0020);
        i_cnt_clr = 1'b1;
        do_read();
        i_cnt_clr = 1'b0;
        n_cmp++; if (o_sec_cnt !== 4'd0 || o_ded_cnt !== 4'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d/%0d exp 0/0", o_sec_cnt, o_ded_cnt); end
        n_cmp++; if (o_sec !== 1'b1 || o_rdata !== 8'h77) begin n_bad++; $display("FAIL clr_read: got %b/%h exp 1/77", o_sec, o_rdata); end
    endtask

    task automatic test_reset_mid();
        do_write(8'h11, 13'h0);
        do_write(8'h22, 13'h0);
        i_rreq = 1'b1;
        step();
        n_cmp++; if (o_rvalid !== 1'b1 || o_rdata !== 8'h11) begin n_bad++; $display("FAIL mid_read: got %b/%h exp 1/11", o_rvalid, o_rdata); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (o_count !== 3'd0 || o_empty !== 1'b1 || o_rvalid !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got %0d/%b/%b exp 0/1/0", o_count, o_empty, o_rvalid); end
        i_rreq = 1'b0;
        step();
        reset_n = 1'b1;
        do_read();
        n_cmp++; if (o_rvalid !== 1'b0 || o_rd_udf !== 1'b1) begin n_bad++; $display("FAIL post_reset_read: got %b/%b exp 0/1", o_rvalid, o_rd_udf); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_sec();
        test_ded();
        test_full();
        test_underflow();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
